// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - shared frontend redirect types and counter widths
package frontend_pkg;

  localparam int SQUASH_W = 3;
  localparam int HOLD_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } redirect_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ROB  = 2'd1,
    BU   = 2'd2,
    DEC  = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect sources plus fetch/decode handshake bundle
interface fetch_redirect_ctrl_if #(
  parameter type T = logic [31:0]
);

  logic rob_flush_valid;
  T     rob_flush_pc;
  logic bu_redirect_valid;
  T     bu_redirect_target;
  logic dec_redirect_valid;
  T     dec_redirect_target;
  logic take_branch;
  T     branch_loc;
  logic fetch_valid;
  logic fetch_ready;
  logic dec_valid;
  logic dec_ready;
  logic frontend_flush;

  modport master (
    output rob_flush_valid, rob_flush_pc,
    output bu_redirect_valid, bu_redirect_target,
    output dec_redirect_valid, dec_redirect_target,
    input  take_branch, branch_loc,
    output fetch_valid,
    input  fetch_ready,
    input  dec_valid,
    output dec_ready,
    input  frontend_flush
  );

  modport slave (
    input  rob_flush_valid, rob_flush_pc,
    input  bu_redirect_valid, bu_redirect_target,
    input  dec_redirect_valid, dec_redirect_target,
    output take_branch, branch_loc,
    input  fetch_valid,
    output fetch_ready,
    output dec_valid,
    input  dec_ready,
    output frontend_flush
  );

endinterface

// File: rtl/redirect_prio_sel.sv
// rtl/redirect_prio_sel.sv - fixed-priority redirect selector (rob > bu > dec) with hold masking
module redirect_prio_sel
  import frontend_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic          rob_valid,
  input  T              rob_target,
  input  logic          bu_valid,
  input  T              bu_target,
  input  logic          dec_valid,
  input  T              dec_target,
  input  logic          hold_active,
  output logic          accept,
  output redirect_src_e source,
  output T              target
);

  always_comb begin
    accept = 1'b0;
    source = NONE;
    target = '0;
    // Losers are dropped outright; nothing is queued for a later cycle.
    if (rob_valid) begin
      accept = 1'b1;
      source = ROB;
      target = rob_target;
    end else if (bu_valid && !hold_active) begin
      accept = 1'b1;
      source = BU;
      target = bu_target;
    end else if (dec_valid && !hold_active) begin
      accept = 1'b1;
      source = DEC;
      target = dec_target;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - redirect sequencing, wrong-path squash and fetch/decode gating
module fetch_redirect_ctrl
  import frontend_pkg::*;
#(
  parameter type T             = logic [31:0],
  parameter int  SQUASH_CYCLES = 1,
  parameter int  HOLD_CYCLES   = 4,
  parameter int  CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_redirect_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     redirect_count
);

  redirect_state_e     state_q, state_d;
  logic [SQUASH_W-1:0] squash_cnt_q, squash_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q;
  T                    branch_loc_q;
  logic [CNT_W-1:0]    redirect_count_q;

  logic                sel_accept;
  redirect_src_e       sel_source;
  T                    sel_target;

  redirect_prio_sel #(.T(T)) u_sel (
    .rob_valid   (bus.rob_flush_valid),
    .rob_target  (bus.rob_flush_pc),
    .bu_valid    (bus.bu_redirect_valid),
    .bu_target   (bus.bu_redirect_target),
    .dec_valid   (bus.dec_redirect_valid),
    .dec_target  (bus.dec_redirect_target),
    .hold_active (hold_cnt_q != '0),
    .accept      (sel_accept),
    .source      (sel_source),
    .target      (sel_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      squash_cnt_q     <= '0;
      hold_cnt_q       <= '0;
      branch_loc_q     <= '0;
      redirect_count_q <= '0;
    end else begin
      if (sel_accept && sel_source == ROB) begin
        hold_cnt_q <= HOLD_W'(HOLD_CYCLES);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end

      // A fresh redirect always restarts the sequence, whatever state we are in.
      if (sel_accept) begin
        state_q          <= REDIRECT;
        squash_cnt_q     <= SQUASH_W'(SQUASH_CYCLES);
        branch_loc_q     <= sel_target;
        redirect_count_q <= redirect_count_q + CNT_W'(1);
      end else begin
        state_q      <= state_d;
        squash_cnt_q <= squash_cnt_d;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    squash_cnt_d       = squash_cnt_q;
    bus.take_branch    = 1'b0;
    bus.frontend_flush = 1'b0;
    bus.dec_valid      = bus.fetch_valid;
    bus.fetch_ready    = bus.dec_ready;
    unique case (state_q)
      IDLE: begin
      end
      REDIRECT: begin
        bus.take_branch    = 1'b1;
        bus.frontend_flush = 1'b1;
        bus.dec_valid      = 1'b0;
        bus.fetch_ready    = 1'b1;
        state_d            = SQUASH;
      end
      SQUASH: begin
        // Keep fetch draining so the stale icache word is consumed and discarded.
        bus.dec_valid   = 1'b0;
        bus.fetch_ready = 1'b1;
        squash_cnt_d    = squash_cnt_q - 1'b1;
        if (squash_cnt_q <= SQUASH_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.branch_loc = branch_loc_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] redirect_count;
  int          n_checks;
  int          n_fail;

  fetch_redirect_ctrl_if #(.T(logic [31:0])) bus_if ();

  fetch_redirect_ctrl #(
    .T             (logic [31:0]),
    .SQUASH_CYCLES (1),
    .HOLD_CYCLES   (4),
    .CNT_W         (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_if.slave),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus_if.rob_flush_valid     = 1'b0;
    bus_if.bu_redirect_valid   = 1'b0;
    bus_if.dec_redirect_valid  = 1'b0;
    bus_if.rob_flush_pc        = '0;
    bus_if.bu_redirect_target  = '0;
    bus_if.dec_redirect_target = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_reqs();
    bus_if.fetch_valid = 1'b0;
    bus_if.dec_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and pass-through
    bus_if.fetch_valid = 1'b1;
    bus_if.dec_ready   = 1'b1;
    #1;
    check_eq("rst_take_branch", 32'(bus_if.take_branch), 32'd0);
    check_eq("rst_branch_loc", bus_if.branch_loc, 32'h0);
    check_eq("rst_flush", 32'(bus_if.frontend_flush), 32'd0);
    check_eq("rst_count", redirect_count, 32'd0);
    check_eq("rst_dec_valid", 32'(bus_if.dec_valid), 32'd1);
    check_eq("rst_fetch_ready", 32'(bus_if.fetch_ready), 32'd1);

    // BU redirect: pulse next cycle, two cycles of squashed dec_valid
    tick();
    bus_if.bu_redirect_valid  = 1'b1;
    bus_if.bu_redirect_target = 32'h100;
    tick();
    clear_reqs();
    bus_if.dec_ready = 1'b0;
    #1;
    check_eq("bu_take_branch", 32'(bus_if.take_branch), 32'd1);
    check_eq("bu_branch_loc", bus_if.branch_loc, 32'h100);
    check_eq("bu_flush", 32'(bus_if.frontend_flush), 32'd1);
    check_eq("bu_dec_valid_n1", 32'(bus_if.dec_valid), 32'd0);
    check_eq("bu_fetch_ready_n1", 32'(bus_if.fetch_ready), 32'd1);
    tick();
    check_eq("bu_take_branch_n2", 32'(bus_if.take_branch), 32'd0);
    check_eq("bu_dec_valid_n2", 32'(bus_if.dec_valid), 32'd0);
    check_eq("bu_fetch_ready_n2", 32'(bus_if.fetch_ready), 32'd1);
    tick();
    check_eq("bu_dec_valid_n3", 32'(bus_if.dec_valid), 32'd1);
    check_eq("bu_fetch_ready_n3", 32'(bus_if.fetch_ready), 32'd0);
    check_eq("bu_count", redirect_count, 32'd1);
    bus_if.dec_ready = 1'b1;

    // Simultaneous requests: ROB wins, single increment
    bus_if.rob_flush_valid     = 1'b1;
    bus_if.rob_flush_pc        = 32'h200;
    bus_if.bu_redirect_valid   = 1'b1;
    bus_if.bu_redirect_target  = 32'h300;
    bus_if.dec_redirect_valid  = 1'b1;
    bus_if.dec_redirect_target = 32'h400;
    tick();
    clear_reqs();
    #1;
    check_eq("prio_take_branch", 32'(bus_if.take_branch), 32'd1);
    check_eq("prio_branch_loc", bus_if.branch_loc, 32'h200);
    check_eq("prio_count", redirect_count, 32'd2);
    for (int i = 0; i < 6; i++) tick();

    // ROB flush at c0, BU at c2 (held off), decode at c5 (eligible)
    bus_if.rob_flush_valid = 1'b1;
    bus_if.rob_flush_pc    = 32'h80;
    tick();
    clear_reqs();
    #1;
    check_eq("hold_rob_loc", bus_if.branch_loc, 32'h80);
    check_eq("hold_rob_take", 32'(bus_if.take_branch), 32'd1);
    tick();
    bus_if.bu_redirect_valid  = 1'b1;
    bus_if.bu_redirect_target = 32'h90;
    tick();
    clear_reqs();
    #1;
    check_eq("hold_bu_ignored", 32'(bus_if.take_branch), 32'd0);
    check_eq("hold_bu_count", redirect_count, 32'd3);
    check_eq("hold_bu_dec_valid", 32'(bus_if.dec_valid), 32'd1);
    tick();
    tick();
    bus_if.dec_redirect_valid  = 1'b1;
    bus_if.dec_redirect_target = 32'hA0;
    tick();
    clear_reqs();
    #1;
    check_eq("hold_dec_take", 32'(bus_if.take_branch), 32'd1);
    check_eq("hold_dec_loc", bus_if.branch_loc, 32'hA0);
    check_eq("hold_dec_count", redirect_count, 32'd4);
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back: decode lands during REDIRECT and restarts it
    bus_if.bu_redirect_valid  = 1'b1;
    bus_if.bu_redirect_target = 32'h40;
    tick();
    clear_reqs();
    bus_if.dec_redirect_valid  = 1'b1;
    bus_if.dec_redirect_target = 32'h60;
    #1;
    check_eq("b2b_take_c1", 32'(bus_if.take_branch), 32'd1);
    check_eq("b2b_loc_c1", bus_if.branch_loc, 32'h40);
    tick();
    clear_reqs();
    #1;
    check_eq("b2b_take_c2", 32'(bus_if.take_branch), 32'd1);
    check_eq("b2b_loc_c2", bus_if.branch_loc, 32'h60);
    check_eq("b2b_dec_valid_c2", 32'(bus_if.dec_valid), 32'd0);
    tick();
    check_eq("b2b_take_c3", 32'(bus_if.take_branch), 32'd0);
    check_eq("b2b_dec_valid_c3", 32'(bus_if.dec_valid), 32'd0);
    tick();
    check_eq("b2b_dec_valid_c4", 32'(bus_if.dec_valid), 32'd1);
    check_eq("b2b_count", redirect_count, 32'd6);

    // IDLE back-pressure mirrored combinationally
    bus_if.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_fetch_ready", 32'(bus_if.fetch_ready), 32'd0);
      check_eq("bp_dec_valid", 32'(bus_if.dec_valid), 32'd1);
      tick();
    end
    bus_if.dec_ready = 1'b1;
    #1;
    check_eq("bp_toggle_hi", 32'(bus_if.fetch_ready), 32'd1);
    bus_if.dec_ready = 1'b0;
    #1;
    check_eq("bp_toggle_lo", 32'(bus_if.fetch_ready), 32'd0);
    bus_if.fetch_valid = 1'b0;
    #1;
    check_eq("bp_fetch_valid_lo", 32'(bus_if.dec_valid), 32'd0);
    bus_if.fetch_valid = 1'b1;
    bus_if.dec_ready   = 1'b1;

    // Reset during REDIRECT; redirect in the reset cycle is dropped
    tick();
    bus_if.bu_redirect_valid  = 1'b1;
    bus_if.bu_redirect_target = 32'h500;
    tick();
    bus_if.bu_redirect_target = 32'h55;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_in_redirect", 32'(bus_if.take_branch), 32'd1);
    tick();
    reset = 1'b0;
    clear_reqs();
    #1;
    check_eq("mid_rst_take", 32'(bus_if.take_branch), 32'd0);
    check_eq("mid_rst_count", redirect_count, 32'd0);
    check_eq("mid_rst_loc", bus_if.branch_loc, 32'h0);
    check_eq("mid_rst_flush", 32'(bus_if.frontend_flush), 32'd0);
    check_eq("mid_rst_dec_valid", 32'(bus_if.dec_valid), 32'd1);
    tick();
    check_eq("mid_rst_take_next", 32'(bus_if.take_branch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
